// File: rtl/comp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : comp_pkg
// Description : Shared types and constants for the sequential magnitude
//               comparator: FSM state encoding, result-vector bit positions
//               and the slice-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

    // Explicit encoding so the state register width is fixed at 2 bits
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the 3-bit {gt, eq, lt} result vector
    localparam int GT = 2;
    localparam int EQ = 1;
    localparam int LT = 0;

    // Number of DIGIT-wide slices in a WIDTH-bit operand (0 guards a bad DIGIT)
    function automatic int num_slices(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comp_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : comp_slice
// Description : DIGIT-bit combinational unsigned magnitude comparator.
//               Exactly one of gt/eq/lt is high for any input pair.
// Ports       : a, b  - DIGIT-bit unsigned operands
//               gt    - a > b
//               eq    - a == b
//               lt    - a < b
// Revision    : 1.0 - initial release
// ============================================================================
module comp_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule
`default_nettype wire

// File: rtl/mag_comp_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mag_comp_seq
// Description : Sequential WIDTH-bit magnitude comparator, signed or unsigned.
//               Scans operands MSB-first, DIGIT bits per cycle, and stops on
//               the first differing slice. Valid/ready on both sides.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid / in_ready   - operand handshake
//               a, b, signed_mode     - operands and compare mode
//               out_valid / out_ready - verdict handshake
//               gt, eq, lt            - registered one-hot verdict
// Revision    : 1.0 - initial release
// ============================================================================
module mag_comp_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int c_NSLICE = num_slices(WIDTH, DIGIT);
    localparam int c_CNT_W  = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;

    // Parameter sanity; DIGIT is tested first so the modulo never divides by 0
    generate
        if ((DIGIT < 1) || ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_bad_params
            $fatal(1, "mag_comp_seq: WIDTH must be a non-zero multiple of DIGIT >= 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_res;

    logic [DIGIT-1:0]   w_sa;
    logic [DIGIT-1:0]   w_sb;
    logic               w_gt;
    logic               w_eq;
    logic               w_lt;
    logic [2:0]         w_slice_res;
    logic               w_first;
    logic               w_last;
    logic               w_finish;

    // Counter still holds its load value only during the first SCAN cycle
    assign w_first  = (r_cnt == c_CNT_W'(c_NSLICE - 1));
    assign w_last   = (r_cnt == '0);
    assign w_finish = !w_eq || w_last;

    // Signed compare: flipping the sign bit maps two's complement onto
    // offset binary, so the remaining slices compare correctly as unsigned
    always_comb begin
        w_sa = r_a[WIDTH-1 -: DIGIT];
        w_sb = r_b[WIDTH-1 -: DIGIT];
        if (w_first && r_signed) begin
            w_sa[DIGIT-1] = ~w_sa[DIGIT-1];
            w_sb[DIGIT-1] = ~w_sb[DIGIT-1];
        end
    end

    comp_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a  (w_sa),
        .b  (w_sb),
        .gt (w_gt),
        .eq (w_eq),
        .lt (w_lt)
    );

    always_comb begin
        w_slice_res     = '0;
        w_slice_res[GT] = w_gt;
        w_slice_res[EQ] = w_eq;
        w_slice_res[LT] = w_lt;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = SCAN;
            SCAN:    if (w_finish)  w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Datapath: operand shift registers, slice counter and verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_cnt    <= c_CNT_W'(c_NSLICE - 1);
                    end
                end
                SCAN: begin
                    if (w_finish) begin
                        // On the last slice an equal result latches eq
                        r_res <= w_slice_res;
                    end else begin
                        r_a   <= r_a << DIGIT;
                        r_b   <= r_b << DIGIT;
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_res <= '0;
                    end
                end
                default: begin
                    r_res <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign gt        = r_res[GT];
    assign eq        = r_res[EQ];
    assign lt        = r_res[LT];

endmodule
`default_nettype wire

// File: tb/tb_mag_comp_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mag_comp_seq
// Description : Directed self-checking bench for mag_comp_seq (16/4).
//               Expected verdicts and latencies are queued when a transaction
//               is driven and popped when the verdict appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mag_comp_seq;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;

    // Expected {gt, eq, lt}
    localparam logic [2:0] c_R_GT = 3'b100;
    localparam logic [2:0] c_R_EQ = 3'b010;
    localparam logic [2:0] c_R_LT = 3'b001;
    localparam logic [2:0] c_R_NONE = 3'b000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             gt;
    logic             eq;
    logic             lt;

    typedef struct {
        string      tag;
        logic [2:0] res;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mag_comp_seq #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic push_exp(input string tag, input logic [2:0] res, input int lat);
        exp_t e;
        e.tag = tag;
        e.res = res;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Present a transaction, wait for acceptance, then scramble the inputs to
    // show they are not sampled after the acceptance edge. Returns at the
    // falling edge after the acceptance edge.
    task automatic send(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sm, input logic [2:0] res, input int lat);
        int w;
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
        push_exp(tag, res, lat);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av; b = ~bv; signed_mode = ~sm;
    endtask

    // Wait (bounded) for out_valid, then check latency and flags. With
    // one_cycle set, out_ready is high and out_valid must last one cycle.
    task automatic receive(input bit one_cycle);
        exp_t e;
        int   lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_latency"}, out_valid ? lat : -1, e.lat);
            chk({e.tag, "_flags"}, int'({gt, eq, lt}), int'(e.res));
            if (one_cycle) begin
                @(negedge clk);
                chk({e.tag, "_valid_one_cycle"}, int'(out_valid), 0);
                chk({e.tag, "_ready_after"}, int'(in_ready), 1);
                chk({e.tag, "_flags_clear"}, int'({gt, eq, lt}), int'(c_R_NONE));
            end
        end
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_flags", int'({gt, eq, lt}), int'(c_R_NONE));
        rst_n = 1'b1;

        // Equal operands: full scan
        send("equal", 16'h1234, 16'h1234, 1'b0, c_R_EQ, 4);
        receive(1'b1);

        // Early exit, unsigned vs signed
        send("msb_unsigned", 16'h8000, 16'h7FFF, 1'b0, c_R_GT, 1);
        receive(1'b1);
        send("msb_signed", 16'h8000, 16'h7FFF, 1'b1, c_R_LT, 1);
        receive(1'b1);

        // Mid-word difference
        send("mid_gt", 16'h12F4, 16'h12A4, 1'b0, c_R_GT, 3);
        receive(1'b1);
        send("mid_lt", 16'h12A4, 16'h12F4, 1'b0, c_R_LT, 3);
        receive(1'b1);

        // Signed negatives
        send("neg_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, c_R_GT, 4);
        receive(1'b1);
        send("signed_0_ffff", 16'h0000, 16'hFFFF, 1'b1, c_R_GT, 1);
        receive(1'b1);
        send("unsigned_0_ffff", 16'h0000, 16'hFFFF, 1'b0, c_R_LT, 1);
        receive(1'b1);

        // Backpressure: verdict held while out_ready is low
        out_ready = 1'b0;
        send("bp", 16'h0010, 16'h0020, 1'b0, c_R_LT, 3);
        receive(1'b0);
        a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; in_valid = 1'b1;
        push_exp("bp_next", c_R_LT, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", i), int'(out_valid), 1);
            chk($sformatf("bp_hold_flags_%0d", i), int'({gt, eq, lt}), int'(c_R_LT));
            chk($sformatf("bp_hold_in_ready_%0d", i), int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_flags", int'({gt, eq, lt}), int'(c_R_NONE));
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hFFFF; b = 16'h0000;
        chk("bp_next_accepted", int'(in_ready), 0);
        receive(1'b1);

        // Reset during SCAN discards the pending result
        send("rst_mid_scan", 16'h1234, 16'h1234, 1'b0, c_R_EQ, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_flags", int'({gt, eq, lt}), int'(c_R_NONE));
        chk("rst_mid_in_ready", int'(in_ready), 1);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_stale_valid_%0d", i), int'(out_valid), 0);
        end
        send("after_reset", 16'h0003, 16'h0001, 1'b0, c_R_GT, 4);
        receive(1'b1);

        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
`default_nettype wire
